// File: rtl/key_debounce_rpt.sv
// -----------------------------------------------------------------------------
// key_debounce_rpt
//   Multi-channel push-button front end. Each of NUM_KEYS raw key pins goes
//   through a 2-flop synchroniser and is normalised so that 1 means pressed.
//   It then passes a stable-for-DEBOUNCE_CYCLES filter that drives
//   key_state and emits one-cycle press / release pulses. While a key is held,
//   an optional auto-repeat generator emits rpt pulses: the first comes
//   REPEAT_DELAY cycles after the press pulse, and later ones every
//   REPEAT_PERIOD cycles. Channels are fully independent.
//
// Ports
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   key_in       in   NUM_KEYS  raw asynchronous key pins
//   key_state    out  NUM_KEYS  debounced level, 1 = pressed
//   press        out  NUM_KEYS  1-cycle pulse on debounced released->pressed
//   key_release  out  NUM_KEYS  1-cycle pulse on debounced pressed->released
//                               ("release" is a reserved word, hence the name)
//   rpt          out  NUM_KEYS  1-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module key_debounce_rpt #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] rpt
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam bit RPT_EN   = (REPEAT_DELAY > 0);

  // Synchroniser flops come out of reset at the released pin level so no
  // spurious change is seen after reset.
  localparam logic [NUM_KEYS-1:0] IDLE_PIN = {NUM_KEYS{ACTIVE_LOW != 0}};

  // Terminal counts: the counter value on the cycle whose increment would
  // reach the target.
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(RPT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REPEAT   = 2'd2
  } rpt_state_e;

  logic [NUM_KEYS-1:0]            sync1_q, sync1_d;
  logic [NUM_KEYS-1:0]            sync2_q, sync2_d;
  logic [NUM_KEYS-1:0]            key_pressed;
  logic [NUM_KEYS-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [NUM_KEYS-1:0]            key_state_q, key_state_d;
  logic [NUM_KEYS-1:0]            press_q, press_d;
  logic [NUM_KEYS-1:0]            release_q, release_d;
  logic [NUM_KEYS-1:0]            rpt_q, rpt_d;
  logic [NUM_KEYS-1:0][HOLD_W-1:0] hold_q, hold_d;
  rpt_state_e                     state_q [NUM_KEYS];
  rpt_state_e                     state_d [NUM_KEYS];

  // Synchroniser and debounce filter
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    key_pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    db_cnt_d    = db_cnt_q;
    key_state_d = key_state_q;
    press_d     = '0;
    release_d   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_pressed[i] != key_state_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          key_state_d[i] = key_pressed[i];
          db_cnt_d[i]    = '0;
          press_d[i]     = key_pressed[i];
          release_d[i]   = ~key_pressed[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        // Any sample matching the accepted level restarts the count.
        db_cnt_d[i] = '0;
      end
    end
  end

  // Auto-repeat FSM, driven by the pulses being registered this same cycle
  // so the first rpt lands exactly REPEAT_DELAY cycles after press.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rpt_d   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!RPT_EN || release_d[i]) begin
        state_d[i] = ST_RELEASED;
        hold_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_RELEASED: begin
            if (press_d[i]) begin
              state_d[i] = ST_WAIT;
              hold_d[i]  = '0;
            end
          end
          ST_WAIT: begin
            if (hold_q[i] == DLY_LAST) begin
              rpt_d[i]   = 1'b1;
              hold_d[i]  = '0;
              state_d[i] = ST_REPEAT;
            end else begin
              hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
          end
          ST_REPEAT: begin
            if (hold_q[i] == PER_LAST) begin
              rpt_d[i]  = 1'b1;
              hold_d[i] = '0;
            end else begin
              hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_RELEASED;
            hold_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= IDLE_PIN;
      sync2_q     <= IDLE_PIN;
      db_cnt_q    <= '0;
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      rpt_q       <= '0;
      hold_q      <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_RELEASED;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      rpt_q       <= rpt_d;
      hold_q      <= hold_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign key_state   = key_state_q;
  assign press       = press_q;
  assign key_release = release_q;
  assign rpt         = rpt_q;

endmodule
